// File: rtl/pd_atan_scheduler.sv
// pd_atan_scheduler: time-shares one lut_atan between the received (r) and decided (a)
// symbol lookups of the phase detector, then emits the wrapped difference atan(r) - atan(a).
module pd_atan_scheduler #(
  parameter int unsigned NB_DATA_IN  = 8,
  parameter int unsigned NB_DATA_OUT = 16,
  parameter int unsigned LUT_LAT     = 1
) (
  input  logic                          i_clock,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic signed [NB_DATA_IN-1:0]  i_rx_i,
  input  logic signed [NB_DATA_IN-1:0]  i_rx_q,
  input  logic signed [NB_DATA_IN-1:0]  i_dec_i,
  input  logic signed [NB_DATA_IN-1:0]  i_dec_q,
  output logic signed [NB_DATA_IN-1:0]  o_lut_i,
  output logic signed [NB_DATA_IN-1:0]  o_lut_q,
  input  logic signed [NB_DATA_OUT-1:0] i_lut_atan,
  output logic signed [NB_DATA_OUT-1:0] o_phase_error,
  output logic                          o_valid
);

  // Counter holds values 0 .. LUT_LAT+2, so it never wraps before the last collection.
  localparam int unsigned CntW = $clog2(LUT_LAT + 3);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] CntSampleR = CntW'(LUT_LAT + 1);
  localparam logic [CntW-1:0] CntSampleA = CntW'(LUT_LAT + 2);

  typedef enum logic [1:0] {
    StIdle,
    StIssueR,
    StIssueA,
    StWait
  } state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic signed [NB_DATA_IN-1:0]  dec_i_q, dec_i_d;
  logic signed [NB_DATA_IN-1:0]  dec_q_q, dec_q_d;
  logic signed [NB_DATA_OUT-1:0] atan_r_q, atan_r_d;
  logic signed [NB_DATA_OUT-1:0] phase_q, phase_d;
  logic                          valid_q, valid_d;
  logic signed [NB_DATA_IN-1:0]  lut_i_q, lut_i_d;
  logic signed [NB_DATA_IN-1:0]  lut_q_q, lut_q_d;

  // Next-state: sequencing of the shared LUT operands and counter-timed angle collection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dec_i_d  = dec_i_q;
    dec_q_d  = dec_q_q;
    atan_r_d = atan_r_q;
    phase_d  = phase_q;
    valid_d  = 1'b0;
    lut_i_d  = '0;
    lut_q_d  = '0;

    if (state_q != StIdle) begin
      cnt_d = cnt_q + CntOne;
    end

    case (state_q)
      StIdle: begin
        if (i_valid) begin
          // The rx operand goes straight into the registered LUT port for the ISSUE_R
          // cycle; only the dec operand has to be held for the following cycle.
          dec_i_d = i_dec_i;
          dec_q_d = i_dec_q;
          lut_i_d = i_rx_i;
          lut_q_d = i_rx_q;
          // Cleared on accept and counted for the ISSUE_R cycle, so ISSUE_R sees 1.
          cnt_d   = CntOne;
          state_d = StIssueR;
        end
      end
      StIssueR: begin
        lut_i_d = dec_i_q;
        lut_q_d = dec_q_q;
        state_d = StIssueA;
      end
      StIssueA: begin
        state_d = StWait;
      end
      StWait: begin
        state_d = StWait;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Collection follows the counter, not the state: with LUT_LAT=1 it lands in ISSUE_A/WAIT.
    if (state_q != StIdle) begin
      if (cnt_q == CntSampleR) begin
        atan_r_d = i_lut_atan;
      end
      if (cnt_q == CntSampleA) begin
        phase_d = atan_r_q - i_lut_atan;  // two's-complement wrap is the intended modulo
        valid_d = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
    end
  end

  // State and registered outputs; async reset aborts any transaction in flight.
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dec_i_q  <= '0;
      dec_q_q  <= '0;
      atan_r_q <= '0;
      phase_q  <= '0;
      valid_q  <= 1'b0;
      lut_i_q  <= '0;
      lut_q_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dec_i_q  <= dec_i_d;
      dec_q_q  <= dec_q_d;
      atan_r_q <= atan_r_d;
      phase_q  <= phase_d;
      valid_q  <= valid_d;
      lut_i_q  <= lut_i_d;
      lut_q_q  <= lut_q_d;
    end
  end

  assign o_ready       = (state_q == StIdle);
  assign o_lut_i       = lut_i_q;
  assign o_lut_q       = lut_q_q;
  assign o_phase_error = phase_q;
  assign o_valid       = valid_q;

endmodule

// File: tb/tb_pd_atan_scheduler.sv
// Bench for pd_atan_scheduler: two instances (LUT_LAT=1 and 3) share stimulus; each gets a
// behavioural LUT returning {lut_i, lut_q} as the angle, and a timeline model checks every cycle.
module tb_pd_atan_scheduler;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        vld_in = 1'b0;
  logic [7:0]  rx_i   = '0;
  logic [7:0]  rx_q   = '0;
  logic [7:0]  dec_i  = '0;
  logic [7:0]  dec_q  = '0;

  logic        rdy1, vld1, rdy3, vld3;
  logic [7:0]  li1, lq1, li3, lq3;
  logic [15:0] err1, err3;
  logic [15:0] atan1 = '0;
  logic [15:0] l3_0 = '0, l3_1 = '0, l3_2 = '0;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pd_atan_scheduler #(.NB_DATA_IN(8), .NB_DATA_OUT(16), .LUT_LAT(1)) u_dut1 (
    .i_clock(clk), .i_rst_n(rst_n), .i_valid(vld_in), .o_ready(rdy1),
    .i_rx_i(rx_i), .i_rx_q(rx_q), .i_dec_i(dec_i), .i_dec_q(dec_q),
    .o_lut_i(li1), .o_lut_q(lq1), .i_lut_atan(atan1),
    .o_phase_error(err1), .o_valid(vld1)
  );

  pd_atan_scheduler #(.NB_DATA_IN(8), .NB_DATA_OUT(16), .LUT_LAT(3)) u_dut3 (
    .i_clock(clk), .i_rst_n(rst_n), .i_valid(vld_in), .o_ready(rdy3),
    .i_rx_i(rx_i), .i_rx_q(rx_q), .i_dec_i(dec_i), .i_dec_q(dec_q),
    .o_lut_i(li3), .o_lut_q(lq3), .i_lut_atan(l3_2),
    .o_phase_error(err3), .o_valid(vld3)
  );

  // Behavioural LUTs: angle = {operand_i, operand_q}, delayed by LUT_LAT cycles.
  always @(posedge clk) atan1 <= {li1, lq1};
  always @(posedge clk) begin
    l3_0 <= {li3, lq3};
    l3_1 <= l3_0;
    l3_2 <= l3_1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Timeline model: a pair accepted in cycle t shows rx on the LUT port in t+1, dec in t+2,
  // and its error with a valid pulse in t+L+3, when the block is ready again.
  bit          m_act  [2];
  int          m_t    [2];
  logic [7:0]  m_ri [2], m_rq [2], m_di [2], m_dq [2];
  logic [15:0] m_pend [2];
  logic [15:0] m_err  [2] = '{16'h0, 16'h0};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int          lat;
      bit          done;
      logic [7:0]  ei, eq;
      lat  = (k == 0) ? 1 : 3;
      done = 1'b0;
      if (!rst_n) begin
        m_act[k] = 1'b0;
        m_err[k] = 16'h0;
      end else if (m_act[k] && cyc == m_t[k] + lat + 3) begin
        done     = 1'b1;
        m_err[k] = m_pend[k];
        m_act[k] = 1'b0;
      end
      ei = 8'h0;
      eq = 8'h0;
      if (m_act[k] && cyc == m_t[k] + 1) begin
        ei = m_ri[k];
        eq = m_rq[k];
      end else if (m_act[k] && cyc == m_t[k] + 2) begin
        ei = m_di[k];
        eq = m_dq[k];
      end
      chk($sformatf("ready[L%0d]", lat), 32'((k == 0) ? rdy1 : rdy3), 32'(!m_act[k]));
      chk($sformatf("valid[L%0d]", lat), 32'((k == 0) ? vld1 : vld3), 32'(done));
      chk($sformatf("perr[L%0d]", lat), 32'((k == 0) ? err1 : err3), 32'(m_err[k]));
      chk($sformatf("lut_i[L%0d]", lat), 32'((k == 0) ? li1 : li3), 32'(ei));
      chk($sformatf("lut_q[L%0d]", lat), 32'((k == 0) ? lq1 : lq3), 32'(eq));
      if (rst_n && !m_act[k] && vld_in) begin
        m_act[k]  = 1'b1;
        m_t[k]    = cyc;
        m_ri[k]   = rx_i;
        m_rq[k]   = rx_q;
        m_di[k]   = dec_i;
        m_dq[k]   = dec_q;
        m_pend[k] = {rx_i, rx_q} - {dec_i, dec_q};
      end
    end
  end

  task automatic randomize_inputs();
    rx_i  = 8'($urandom);
    rx_q  = 8'($urandom);
    dec_i = 8'($urandom);
    dec_q = 8'($urandom);
  endtask

  // One pair into both idle instances; pins latency, LUT port order and result literally.
  task automatic run_pair(input logic [7:0] ri, input logic [7:0] rq, input logic [7:0] di,
                          input logic [7:0] dq, input logic [15:0] exp);
    int          lat1, lat3;
    logic [15:0] e1, e3;
    lat1 = -1;
    lat3 = -1;
    e1   = '0;
    e3   = '0;
    @(posedge clk); #1;
    rx_i = ri; rx_q = rq; dec_i = di; dec_q = dq; vld_in = 1'b1;
    @(posedge clk); #1;
    vld_in = 1'b0;
    randomize_inputs();  // changes while busy must not reach the result
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (vld1 && lat1 < 0) begin lat1 = n; e1 = err1; end
      if (vld3 && lat3 < 0) begin lat3 = n; e3 = err3; end
      if (n <= 5) chk("busy_ready[L3]", 32'(rdy3), 32'd0);
      if (n == 1) chk("issue_r[L1]", 32'(li1), 32'(ri));
      if (n == 2) chk("issue_a[L1]", 32'(li1), 32'(di));
    end
    chk("latency[L1]", 32'(lat1), 32'd4);
    chk("latency[L3]", 32'(lat3), 32'd6);
    chk("result[L1]", 32'(e1), 32'(exp));
    chk("result[L3]", 32'(e3), 32'(exp));
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(rdy1), 32'd1);
    chk("reset_perr", 32'(err1), 32'd0);

    run_pair(8'h20, 8'h00, 8'h00, 8'h00, 16'h2000);
    run_pair(8'h70, 8'h00, 8'h90, 8'h00, 16'hE000);
    run_pair(8'h80, 8'h00, 8'h00, 8'h01, 16'h7FFF);

    // Back-to-back: valid held for 20 cycles; L1 instance accepts every 4 cycles.
    pulses = 0;
    for (int i = 0; i <= 20; i++) begin
      @(posedge clk); #1;
      vld_in = (i < 20);
      randomize_inputs();
      @(negedge clk);
      if (vld1) pulses++;
    end
    chk("b2b_pulses[L1]", 32'(pulses), 32'd5);
    vld_in = 1'b0;
    repeat (10) @(posedge clk);

    // Reset in cycle 2 after accept aborts the transaction.
    @(posedge clk); #1;
    rx_i = 8'h11; rx_q = 8'h22; dec_i = 8'h33; dec_q = 8'h44; vld_in = 1'b1;
    @(posedge clk); #1;
    vld_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(rdy1), 32'd1);
    chk("abort_perr", 32'(err1), 32'd0);
    chk("abort_valid", 32'(vld1), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    run_pair(8'h12, 8'h34, 8'h56, 8'h78, 16'hBBBC);

    // Random traffic with rare resets; every cycle is checked against the model.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      rst_n  = ($urandom_range(63) != 0);
      vld_in = 1'($urandom_range(1));
      randomize_inputs();
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    vld_in = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pd_atan_scheduler.md
# pd_atan_scheduler

Sequencer that time-shares one `lut_atan` instance between the two angle lookups the phase detector needs per symbol: the received symbol (r) and the decided symbol (a). It captures one symbol pair, issues r then a to the shared LUT on consecutive cycles, and collects both angles at the LUT latency. It then outputs the wrapped phase error atan(r) − atan(a) with a valid pulse. It sits between the slicer/symbol source and the loop filter, replacing the two-LUT arrangement in the phase detector.

## Interface
- `NB_DATA_IN`, 8, width of signed I/Q components.
- `NB_DATA_OUT`, 16, width of signed angle; full scale ±π maps to ±2^(NB_DATA_OUT−1).
- `LUT_LAT`, 1, LUT latency: a value on `o_lut_i`/`o_lut_q` in cycle k appears on `i_lut_atan` in cycle k+LUT_LAT. Legal range is ≥1.
- `i_clock`  in  1  single clock for the whole block.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  symbol pair present on `i_rx_*`/`i_dec_*`.
- `o_ready`  out  1  block accepts a pair; equals (state==IDLE).
- `i_rx_i`, `i_rx_q`  in  NB_DATA_IN  signed received symbol.
- `i_dec_i`, `i_dec_q`  in  NB_DATA_IN  signed decided symbol.
- `o_lut_i`, `o_lut_q`  out  NB_DATA_IN  signed operand to the shared `lut_atan`.
- `i_lut_atan`  in  NB_DATA_OUT  signed angle returned by `lut_atan`.
- `o_phase_error`  out  NB_DATA_OUT  signed atan(r) − atan(a), modulo 2^NB_DATA_OUT.
- `o_valid`  out  1  one-cycle pulse; `o_phase_error` is new this cycle.

## Operation
- States: IDLE, ISSUE_R, ISSUE_A, WAIT.
  - IDLE: if `i_valid`, register all four inputs, clear the cycle counter, and go to ISSUE_R.
  - ISSUE_R: drive the registered rx operand on `o_lut_*`; go to ISSUE_A.
  - ISSUE_A: drive the registered dec operand on `o_lut_*`; go to WAIT.
  - WAIT: hold until collection completes, then go to IDLE.
- Cycle counter: cleared on accept, incremented every cycle outside IDLE. Counter value 1 corresponds to ISSUE_R.
- Collection:
  - At counter == 1+LUT_LAT, register `i_lut_atan` as atan_r.
  - At counter == 2+LUT_LAT, register o_phase_error ← atan_r − `i_lut_atan`, truncated to NB_DATA_OUT bits (two's-complement wrap, no saturation). Set `o_valid` ← 1 and go to IDLE.
  - For LUT_LAT=1 these collection points fall in ISSUE_A and WAIT; the counter, not the state, governs collection.
- `o_lut_*` is 0 in IDLE and WAIT.
- `i_valid` outside IDLE is ignored. There is no queueing; the upstream source must hold or drop the pair.
- Input operands are captured only on accept; later input changes do not affect the result in flight.
- `o_phase_error` holds its last value between pulses.

## Timing
- Reset (async assert) values:
  - state IDLE, so `o_ready`=1;
  - `o_valid`=0, `o_phase_error`=0, `o_lut_i`=`o_lut_q`=0;
  - counter and atan_r cleared.
- Accept at the edge ending cycle 0. ISSUE_R in cycle 1, ISSUE_A in cycle 2.
- atan_r is sampled in cycle 1+LUT_LAT and atan_a in cycle 2+LUT_LAT.
- `o_valid`=1 and `o_ready`=1 in cycle 3+LUT_LAT. Latency is LUT_LAT+3 cycles from accept to `o_valid`.
- A new pair may be accepted in the same cycle `o_valid` is high. Sustained throughput is one pair per LUT_LAT+3 cycles.
- Reset asserted mid-operation aborts the transaction: no `o_valid` for it, and outputs return to their reset values immediately.
- Counter width is ≥ clog2(LUT_LAT+3); it must not wrap before collection completes.

## Test plan
Bench uses a behavioural LUT model with latency LUT_LAT, mapping the operand pair to a programmable angle.
- Basic, LUT_LAT=1: r→0x2000, a→0x0000 -> `o_valid` in cycle 4 after accept, `o_phase_error`=0x2000; `o_lut_*` shows rx in cycle 1, dec in cycle 2, 0 otherwise.
- Wrap: r→0x7000, a→0x9000 -> `o_phase_error`=0xE000 (−8192), not saturated. Also r→0x8000, a→0x0001 -> 0x7FFF.
- Latency param, LUT_LAT=3: any pair -> `o_valid` exactly 6 cycles after accept; `o_ready` low in cycles 1..5.
- Back-to-back and ignore:
  - `i_valid` held high for 20 cycles, LUT_LAT=1 -> accepts every 4 cycles, 5 pulses with correct per-pair errors.
  - Input changes while busy do not alter the result.
- Reset mid-op: assert `i_rst_n`=0 in cycle 2 after accept -> no `o_valid`, `o_phase_error`=0, `o_ready`=1. The next pair after release completes normally.
